// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, programmable instruction memory and LOAD/RUN controller.
// Define FETCH_COUNT_EN to build the 16-bit fetched-instruction counter.
module instruction_fetch_unit #(
  parameter int PC_WIDTH   = 6,
  parameter int IMEM_DEPTH = 64,
  parameter int RESET_PC   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                prog_we,
  input  logic [PC_WIDTH-1:0] prog_addr,
  input  logic [7:0]          prog_data,
  output logic [7:0]          Instruction_Codep,
  output logic [PC_WIDTH-1:0] pc,
  output logic                jump_taken,
  output logic                running,
  output logic [15:0]         fetch_count
);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);

  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]          imem_q [IMEM_DEPTH];
  logic [7:0]          instr;
  logic                is_run;
  logic                advance;

  // Jumps take their target from the low PC_WIDTH bits of the opcode.
  function automatic logic [PC_WIDTH-1:0] next_pc(input logic [PC_WIDTH-1:0] cur,
                                                  input logic [7:0]          ins);
    if (ins[7:6] == 2'b11) return ins[PC_WIDTH-1:0];
    return cur + PC_WIDTH'(1);
  endfunction

  assign is_run  = (state_q == ST_RUN);
  assign advance = is_run && !stall;
  assign instr   = imem_q[pc_q];

  assign Instruction_Codep = is_run ? instr : 8'h00;
  assign pc                = pc_q;
  assign running           = is_run;
  assign jump_taken        = advance && (Instruction_Codep[7:6] == 2'b11);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (!is_run) begin
      pc_d = PC_RST;
      if (start) state_d = ST_RUN;
    end else if (!stall) begin
      pc_d = next_pc(pc_q, instr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Program memory has no reset so a downloaded program survives reset.
  always_ff @(posedge clk) begin
    if (!is_run && prog_we) imem_q[prog_addr] <= prog_data;
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  assign fcnt_d      = advance ? fcnt_q + 16'd1 : fcnt_q;
  assign fetch_count = fcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fcnt_q <= 16'h0000;
    else        fcnt_q <= fcnt_d;
  end
`else
  assign fetch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit against a program-level reference model.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, stall, prog_we;
  logic [5:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] Instruction_Codep;
  logic [5:0] pc;
  logic       jump_taken, running;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  ins;
    logic [5:0]  pc;
    logic        jt;
    logic        run;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];

  // Reference machine state: a program in an array, a PC, a mode flag, a counter.
  logic [7:0] m_mem [64];
  int         m_pc;
  bit         m_run;
  int         m_fc;

  instruction_fetch_unit #(.PC_WIDTH(6), .IMEM_DEPTH(64), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset_n), .start(start), .stall(stall),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .Instruction_Codep(Instruction_Codep), .pc(pc), .jump_taken(jump_taken),
    .running(running), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("instr", {8'h00, Instruction_Codep}, {8'h00, e.ins});
      chk("pc", {10'h000, pc}, {10'h000, e.pc});
      chk("jump_taken", {15'h0, jump_taken}, {15'h0, e.jt});
      chk("running", {15'h0, running}, {15'h0, e.run});
      chk("fetch_count", fetch_count, e.fc);
    end
  end

  function automatic bit is_jump(input logic [7:0] w);
    return (w >> 6) == 8'd3;
  endfunction

  task automatic push_expect(input logic sl);
    exp_t e;
    e.ins = m_run ? m_mem[m_pc] : 8'h00;
    e.pc  = 6'(m_pc);
    e.jt  = m_run && !sl && is_jump(e.ins);
    e.run = m_run;
`ifdef FETCH_COUNT_EN
    e.fc  = 16'(m_fc);
`else
    e.fc  = 16'h0000;
`endif
    exp_q.push_back(e);
  endtask

  task automatic model_step(input logic st, input logic sl, input logic we,
                            input logic [5:0] a, input logic [7:0] d);
    if (!m_run) begin
      if (we) m_mem[a] = d;
      if (st) m_run = 1'b1;
    end else if (!sl) begin
      m_fc = (m_fc + 1) % 65536;
      if (is_jump(m_mem[m_pc])) m_pc = m_mem[m_pc] % 64;
      else                      m_pc = (m_pc + 1) % 64;
    end
  endtask

  task automatic cycle(input logic st, input logic sl, input logic we,
                       input logic [5:0] a, input logic [7:0] d);
    start = st; stall = sl; prog_we = we; prog_addr = a; prog_data = d;
    push_expect(sl);
    @(posedge clk); #1;
    model_step(st, sl, we, a, d);
  endtask

  task automatic do_reset();
    start = 0; stall = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
    reset_n = 1'b0;
    m_run = 1'b0; m_pc = 0; m_fc = 0;
    push_expect(1'b0);
    @(negedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 6) == 0,
            6'($urandom), 8'($urandom));
  endtask

  initial begin
    reset_n = 1'b1;
    start = 0; stall = 0; prog_we = 0; prog_addr = '0; prog_data = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    m_run = 0; m_pc = 0; m_fc = 0;
    #2;
    do_reset();

    // Program: 01 02 03 C0 then random non-jump filler.
    for (int i = 0; i < 64; i++) begin
      logic [7:0] w;
      case (i)
        0: w = 8'h01;
        1: w = 8'h02;
        2: w = 8'h03;
        3: w = 8'hC0;
        default: w = 8'($urandom % 192);
      endcase
      cycle(1'b0, 1'b0, 1'b1, 6'(i), w);
    end
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 6'd1, 8'hAA);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    run_random(40);

    // Reset mid-run between edges, then restart on the retained program.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);

    // Write and start in the same LOAD cycle.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 6'd0, 8'h7E);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);

    // Full wrap-around over a program of 0x05 words.
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, 1'b1, 6'(i), 8'h05);
    cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    for (int i = 0; i < 66; i++) cycle(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);

    // Self-jump at address 2.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 6'd2, 8'hC2);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'($urandom % 2), 1'b0, 6'd0, 8'h00);

    // Random programs with random control.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 64; i++) cycle(1'b0, 1'b0, 1'b1, 6'(i), 8'($urandom));
      cycle(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
      run_random(120);
    end

    start = 0; stall = 0; prog_we = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
